// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - shared state encodings, timing constants and Rn field layout for the conv sequencer
package conv_seq_pkg;

  localparam int N_WLOAD    = 81;
  localparam int GROUP_LEN  = 10;
  localparam int GAP_CYC    = 2;
  localparam int RES_LAT    = 4;
  localparam int FIFO_DEPTH = 16;

  // LAT length chosen so the capture edge lands RES_LAT cycles after the last IN=1 cycle
  localparam int LAT_CYC = RES_LAT - GAP_CYC + 1;

  localparam int RN_IN_BIT  = 0;
  localparam int RN_WEN_LSB = 1;
  localparam int RN_WEN_W   = 7;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WLOAD    = 3'd1;
  localparam logic [2:0] S_RUN_WAIT = 3'd2;
  localparam logic [2:0] S_FEED     = 3'd3;
  localparam logic [2:0] S_GAP      = 3'd4;
  localparam logic [2:0] S_LAT      = 3'd5;
  localparam logic [2:0] S_RESULT   = 3'd6;

  function automatic logic [15:0] rn_word(input logic in_bit, input logic [RN_WEN_W-1:0] wen);
    logic [15:0] w;
    w = 16'd0;
    w[RN_IN_BIT] = in_bit;
    w[RN_WEN_LSB +: RN_WEN_W] = wen;
    return w;
  endfunction

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// rtl/conv_seq_ctrl_if.sv - weight, pixel and result handshakes between CPU side and the conv sequencer
interface conv_seq_ctrl_if;

  logic        w_valid;
  logic        w_ready;
  logic [15:0] w_data;
  logic        px_valid;
  logic        px_ready;
  logic [15:0] px_data;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_index;

  modport slave (
    input  w_valid, w_data, px_valid, px_data, res_ready,
    output w_ready, px_ready, res_valid, res_index
  );

  modport master (
    output w_valid, w_data, px_valid, px_data, res_ready,
    input  w_ready, px_ready, res_valid, res_index
  );

endinterface

// File: rtl/conv_px_fifo.sv
// rtl/conv_px_fifo.sv - pixel FIFO with occupancy count, power-of-2 depth, synchronous flush
module conv_px_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && (cnt_q != '0);
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - conv sequencer: weight load, grouped pixel feed, result return
// Optional perf_groups counter built only when CONV_SEQ_PERF_EN is defined.
module conv_seq_ctrl
  import conv_seq_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic                   cfg_abort,
  conv_seq_ctrl_if.slave         bus,
  output logic                   busy,
  output logic                   wload_done,
  output logic [15:0]            perf_groups,
  output logic [15:0]            acc_Rm,
  output logic [15:0]            acc_Rn,
  input  logic [3:0]             acc_max_index
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]    state_q, state_d;
  logic [6:0]    k_q, k_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [15:0]   rm_q, rm_d;
  logic [15:0]   rn_q, rn_d;
  logic          res_valid_q, res_valid_d;
  logic [3:0]    res_idx_q, res_idx_d;
  logic          wdone_q, wdone_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic [15:0]   fifo_rdata;
  logic          px_rdy;
  logic          push;
  logic          pop;
  logic          w_acc;
  logic          res_hs;
  logic          grp_ready;

  assign px_rdy    = !fifo_full && (state_q != S_IDLE);
  assign push      = bus.px_valid && px_rdy && !cfg_abort;
  assign pop       = (state_q == S_FEED);
  assign w_acc     = bus.w_valid && (state_q == S_WLOAD);
  assign res_hs    = res_valid_q && bus.res_ready;
  assign grp_ready = (fifo_count >= CW'(GROUP_LEN));

  conv_px_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (16)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst     (rst),
    .flush_i (cfg_abort),
    .push_i  (push),
    .data_i  (bus.px_data),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    rm_d        = 16'd0;
    rn_d        = 16'd0;
    res_valid_d = res_valid_q;
    res_idx_d   = res_idx_q;
    wdone_d     = wdone_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d = S_WLOAD;
          k_d     = 7'd1;
          wdone_d = 1'b0;
        end
      end
      S_WLOAD: begin
        if (w_acc) begin
          rm_d = bus.w_data;
          rn_d = rn_word(1'b0, k_q);
          k_d  = k_q + 7'd1;
          if (k_q == 7'(N_WLOAD)) begin
            state_d = S_RUN_WAIT;
            wdone_d = 1'b1;
          end
        end
      end
      S_RUN_WAIT: begin
        if (cfg_start) begin
          state_d = S_WLOAD;
          k_d     = 7'd1;
          wdone_d = 1'b0;
        end else if (grp_ready) begin
          state_d = S_FEED;
          cnt_d   = 8'd0;
        end
      end
      S_FEED: begin
        // only entered with a whole group buffered, so every pop here is valid
        rm_d  = fifo_rdata;
        rn_d  = rn_word(1'b1, 7'd0);
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(GROUP_LEN - 1)) begin
          state_d = S_GAP;
          cnt_d   = 8'd0;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(GAP_CYC - 1)) begin
          state_d = S_LAT;
          cnt_d   = 8'd0;
        end
      end
      S_LAT: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(LAT_CYC - 1)) begin
          state_d     = S_RESULT;
          res_idx_d   = acc_max_index;
          res_valid_d = 1'b1;
          cnt_d       = 8'd0;
        end
      end
      S_RESULT: begin
        if (res_hs) begin
          res_valid_d = 1'b0;
          cnt_d       = 8'd0;
          state_d     = grp_ready ? S_FEED : S_RUN_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (cfg_abort) begin
      state_d     = S_IDLE;
      cnt_d       = 8'd0;
      rm_d        = 16'd0;
      rn_d        = 16'd0;
      res_valid_d = 1'b0;
      wdone_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= 7'd0;
      cnt_q       <= 8'd0;
      rm_q        <= 16'd0;
      rn_q        <= 16'd0;
      res_valid_q <= 1'b0;
      res_idx_q   <= 4'd0;
      wdone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      rm_q        <= rm_d;
      rn_q        <= rn_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      wdone_q     <= wdone_d;
    end
  end

`ifdef CONV_SEQ_PERF_EN
  logic [15:0] perf_q;
  always_ff @(posedge clk_i) begin
    if (rst || cfg_abort) begin
      perf_q <= 16'd0;
    end else if (res_hs) begin
      perf_q <= perf_q + 16'd1;
    end
  end
  assign perf_groups = perf_q;
`else
  assign perf_groups = 16'd0;
`endif

  assign bus.w_ready   = (state_q == S_WLOAD);
  assign bus.px_ready  = px_rdy;
  assign bus.res_valid = res_valid_q;
  assign bus.res_index = res_idx_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_RUN_WAIT);
  assign wload_done    = wdone_q;
  assign acc_Rm        = rm_q;
  assign acc_Rn        = rn_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb/tb_conv_seq_ctrl.sv - self-checking bench for conv_seq_ctrl with a behavioural conv/sequencer model
`timescale 1ns/1ps
module tb_conv_seq_ctrl;
  import conv_seq_pkg::*;

`ifdef CONV_SEQ_PERF_EN
  localparam int PERF_ON = 1;
`else
  localparam int PERF_ON = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_abort = 1'b0;
  logic        busy;
  logic        wload_done;
  logic [15:0] perf_groups;
  logic [15:0] acc_Rm;
  logic [15:0] acc_Rn;
  logic [3:0]  acc_max_index = 4'd0;

  conv_seq_ctrl_if bus();

  conv_seq_ctrl dut (
    .clk_i         (clk_i),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_abort     (cfg_abort),
    .bus           (bus),
    .busy          (busy),
    .wload_done    (wload_done),
    .perf_groups   (perf_groups),
    .acc_Rm        (acc_Rm),
    .acc_Rn        (acc_Rn),
    .acc_max_index (acc_max_index)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [3:0] res_of(input int n);
    return (n == 0) ? 4'd7 : 4'((n * 5 + 3) % 16);
  endfunction

  // model state: accepted words, group/result bookkeeping, conv result timing
  logic [15:0] pq[$];
  logic [3:0]  resq[$];
  logic        pend_w = 1'b0;
  logic [15:0] pend_d = 16'd0;
  logic [3:0]  cur_res = 4'd0;
  logic        prev_rv = 1'b0;
  int next_k = 1, run_len = 0, gap_len = 100, since_in = 100;
  int grp_n = 0, grp_done = 0, n_wr = 0, n_res = 0;

  initial forever begin
    @(negedge clk_i);
    if (rst) begin
      pq.delete();
      resq.delete();
      pend_w = 1'b0;
      next_k = 1;
      run_len = 0;
      gap_len = 100;
      since_in = 100;
      prev_rv = 1'b0;
    end else begin
      if (pend_w) begin
        chk("wen_k", 32'(acc_Rn), 32'(next_k * 2));
        chk("w_rm", 32'(acc_Rm), 32'(pend_d));
        next_k++;
        n_wr++;
      end else if (acc_Rn[0]) begin
        chk("rn_feed", 32'(acc_Rn), 32'd1);
        if (run_len == 0) begin
          chk("gap_ok", 32'(gap_len >= GAP_CYC), 32'd1);
          cur_res = res_of(grp_n);
          grp_n++;
        end
        run_len++;
        chk("px_rm", 32'(acc_Rm), (pq.size() != 0) ? 32'(pq.pop_front()) : 32'hDEAD_0000);
      end else begin
        chk("acc_idle", {acc_Rn, acc_Rm}, 32'd0);
      end
      if (acc_Rn[0]) begin
        since_in = 0;
      end else begin
        if (since_in < 1000) since_in++;
        if (run_len > 0) begin
          chk("run_len", 32'(run_len), 32'(GROUP_LEN));
          resq.push_back(cur_res);
          grp_done++;
          run_len = 0;
          gap_len = 0;
        end
        gap_len++;
      end
      if (bus.res_valid && !prev_rv) begin
        chk("res_lat", 32'(since_in), 32'(RES_LAT + 1));
      end
      if (bus.res_valid && bus.res_ready && !cfg_abort) begin
        n_res++;
        chk("res_index", 32'(bus.res_index), (resq.size() != 0) ? 32'(resq.pop_front()) : 32'hDEAD);
      end
      prev_rv = bus.res_valid;
      acc_max_index = (since_in >= RES_LAT) ? cur_res : ~cur_res;
      pend_w = bus.w_valid && bus.w_ready && !cfg_abort;
      pend_d = bus.w_data;
      if (cfg_start && !cfg_abort) next_k = 1;
      if (bus.px_valid && bus.px_ready && !cfg_abort) pq.push_back(bus.px_data);
      if (cfg_abort) begin
        pq.delete();
        resq.delete();
        run_len = 0;
        gap_len = 100;
      end
    end
  end

  task automatic load_weights(input int stall_at, input int n_words);
    int k, stalls, g;
    logic acc;
    k = 1;
    stalls = 0;
    g = 0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("wdone_clr", 32'(wload_done), 32'd0);
    chk("wready_on", 32'(bus.w_ready), 32'd1);
    chk("busy_wload", 32'(busy), 32'd1);
    while (k <= n_words && g < 1000) begin
      if (k == stall_at && stalls < 5) begin
        bus.w_valid = 1'b0;
        stalls++;
      end else begin
        bus.w_valid = 1'b1;
        bus.w_data = 16'h7F00 + 16'(k);
      end
      acc = bus.w_valid && bus.w_ready;
      tick();
      g++;
      if (acc) k++;
    end
    bus.w_valid = 1'b0;
    if (g >= 1000) chk("wload_timeout", 32'(g), 32'd0);
  endtask

  task automatic push_px(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      g = 0;
      bus.px_valid = 1'b1;
      bus.px_data = 16'(first + i);
      while (!bus.px_ready && g < 500) begin
        tick();
        g++;
      end
      if (g >= 500) chk("px_timeout", 32'(g), 32'd0);
      tick();
    end
    bus.px_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rm"}, 32'(acc_Rm), 32'd0);
    chk({tag, "_rn"}, 32'(acc_Rn), 32'd0);
    chk({tag, "_rv"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_wdone"}, 32'(wload_done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_wready"}, 32'(bus.w_ready), 32'd0);
    chk({tag, "_perf"}, 32'(perf_groups), 32'd0);
  endtask

  initial begin
    int base;
    bus.w_valid = 1'b0;
    bus.w_data = 16'd0;
    bus.px_valid = 1'b0;
    bus.px_data = 16'd0;
    bus.res_ready = 1'b0;

    rst = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    chk("reset_pxready", 32'(bus.px_ready), 32'd0);
    chk("reset_ridx", 32'(bus.res_index), 32'd0);
    rst = 1'b0;
    tick();

    // 1: full load without stalls
    n_wr = 0;
    load_weights(0, N_WLOAD);
    chk("load1_wdone", 32'(wload_done), 32'd1);
    chk("load1_wready", 32'(bus.w_ready), 32'd0);
    chk("load1_last_rn", 32'(acc_Rn), 32'h00A2);
    chk("load1_last_rm", 32'(acc_Rm), 32'h7F51);
    tick();
    chk("load1_nwr", 32'(n_wr), 32'd81);
    chk("load1_busy", 32'(busy), 32'd0);

    // 2: reload with a 5-cycle stall in front of word 40
    n_wr = 0;
    load_weights(40, N_WLOAD);
    chk("load2_wdone", 32'(wload_done), 32'd1);
    chk("load2_last_rn", 32'(acc_Rn), 32'h00A2);
    tick();
    chk("load2_nwr", 32'(n_wr), 32'd81);

    // 3: one group 11..20, conv reports 7
    push_px(11, 10);
    for (int g = 0; g < 100 && !bus.res_valid; g++) tick();
    chk("res3_seen", 32'(bus.res_valid), 32'd1);
    chk("res3_idx", 32'(bus.res_index), 32'd7);
    chk("grp3", 32'(grp_done), 32'd1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("res3_clr", 32'(bus.res_valid), 32'd0);

    // 4: 25 pixels with res_ready held: two groups, five words left over
    bus.res_ready = 1'b1;
    push_px(100, 25);
    for (int g = 0; g < 400 && n_res < 3; g++) tick();
    repeat (30) tick();
    chk("grp4", 32'(grp_done), 32'd3);
    chk("res4_n", 32'(n_res), 32'd3);
    chk("fifo_left", 32'(dut.u_fifo.count_o), 32'd5);
    chk("perf4", 32'(perf_groups), (PERF_ON != 0) ? 32'd3 : 32'd0);
    bus.res_ready = 1'b0;

    // 5: abort in the middle of a group
    push_px(125, 5);
    for (int g = 0; g < 50 && !acc_Rn[0]; g++) tick();
    chk("feed5_start", 32'(acc_Rn), 32'd1);
    tick();
    tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    check_all_zero("abort");
    chk("abort_fifo", 32'(dut.u_fifo.count_o), 32'd0);
    chk("abort_pxready", 32'(bus.px_ready), 32'd0);

    // 6: three more groups after a fresh load
    load_weights(0, N_WLOAD);
    base = n_res;
    bus.res_ready = 1'b1;
    push_px(200, 30);
    for (int g = 0; g < 600 && n_res < base + 3; g++) tick();
    repeat (20) tick();
    bus.res_ready = 1'b0;
    chk("res6_n", 32'(n_res - base), 32'd3);
    chk("perf6", 32'(perf_groups), (PERF_ON != 0) ? 32'd3 : 32'd0);
    chk("fifo6", 32'(dut.u_fifo.count_o), 32'd0);

    // reset in the middle of a weight load
    load_weights(0, 20);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check_all_zero("rst_mid");
    rst = 1'b0;
    repeat (3) tick();
    chk("post_rst_idle", {acc_Rn, acc_Rm}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
